// File: rtl/tick_key_conditioner_if.sv
// Bundles the mode/key inputs and pulse outputs of tick_key_conditioner.
// master drives the raw inputs; slave is the conditioner itself.
interface tick_key_conditioner_if;
  logic Run;
  logic Key_Add_N;
  logic Key_Sub_N;
  logic Tick_out;
  logic Add;
  logic Subtract;

  modport master (
    output Run, Key_Add_N, Key_Sub_N,
    input  Tick_out, Add, Subtract
  );

  modport slave (
    input  Run, Key_Add_N, Key_Sub_N,
    output Tick_out, Add, Subtract
  );
endinterface

// File: rtl/tick_key_conditioner.sv
// 1 Hz tick prescaler plus debounced, auto-repeating Add/Subtract key pulses.
// At most one of Tick_out, Add and Subtract is high in any cycle.
module tick_key_conditioner #(
  parameter int unsigned CLK_DIV         = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
  input logic                   Clk_50MHz,
  input logic                   Reset_N,
  tick_key_conditioner_if.slave bus
);

  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);
  localparam int unsigned DEB_W   = $clog2((DEBOUNCE_CYCLES > 2) ? DEBOUNCE_CYCLES : 2);
  localparam int unsigned REP_W   = $clog2((REP_MAX > 2) ? REP_MAX : 2);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] RD_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] RP_LAST  = REP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RELEASED,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE
  } key_state_t;

  // Index 0 is the Add key, index 1 the Subtract key.
  logic [1:0]       sync1_q, sync2_q;
  key_state_t       state_q [2];
  key_state_t       state_d [2];
  logic [DEB_W-1:0] deb_q [2];
  logic [DEB_W-1:0] deb_d [2];
  logic [REP_W-1:0] rep_q [2];
  logic [REP_W-1:0] rep_d [2];
  logic [1:0]       armed_q, armed_d;
  logic [1:0]       press_ev, rep_ev;

  logic [DIV_W-1:0] div_q, div_d;
  logic             pend_q, pend_d;
  logic [1:0]       defer_q, defer_d;
  logic             tick_req, both_held, add_ev, sub_ev;
  logic [1:0]       cand;
  logic             tick_d, add_d, sub_d;

  always_ff @(posedge Clk_50MHz) begin
    if (!Reset_N) begin
      sync1_q      <= 2'b11;
      sync2_q      <= 2'b11;
      armed_q      <= 2'b00;
      div_q        <= '0;
      pend_q       <= 1'b0;
      defer_q      <= 2'b00;
      bus.Tick_out <= 1'b0;
      bus.Add      <= 1'b0;
      bus.Subtract <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        state_q[k] <= RELEASED;
        deb_q[k]   <= '0;
        rep_q[k]   <= '0;
      end
    end else begin
      sync1_q      <= {bus.Key_Sub_N, bus.Key_Add_N};
      sync2_q      <= sync1_q;
      armed_q      <= armed_d;
      div_q        <= div_d;
      pend_q       <= pend_d;
      defer_q      <= defer_d;
      bus.Tick_out <= tick_d;
      bus.Add      <= add_d;
      bus.Subtract <= sub_d;
      for (int k = 0; k < 2; k++) begin
        state_q[k] <= state_d[k];
        deb_q[k]   <= deb_d[k];
        rep_q[k]   <= rep_d[k];
      end
    end
  end

  // armed_q marks that the initial hold delay has passed; later repeats use the shorter period.
  always_comb begin
    press_ev = 2'b00;
    rep_ev   = 2'b00;
    armed_d  = armed_q;
    for (int k = 0; k < 2; k++) begin
      state_d[k] = state_q[k];
      deb_d[k]   = deb_q[k];
      rep_d[k]   = rep_q[k];
      case (state_q[k])
        RELEASED: begin
          if (!sync2_q[k]) begin
            state_d[k] = DEB_PRESS;
            deb_d[k]   = '0;
          end
        end
        DEB_PRESS: begin
          if (sync2_q[k]) begin
            state_d[k] = RELEASED;
          end else if (deb_q[k] == DEB_LAST) begin
            state_d[k]  = PRESSED;
            press_ev[k] = 1'b1;
            rep_d[k]    = '0;
            armed_d[k]  = 1'b0;
          end else begin
            deb_d[k] = deb_q[k] + DEB_W'(1);
          end
        end
        PRESSED: begin
          if (sync2_q[k]) begin
            state_d[k] = DEB_RELEASE;
            deb_d[k]   = '0;
          end else if (rep_q[k] == (armed_q[k] ? RP_LAST : RD_LAST)) begin
            rep_ev[k]  = 1'b1;
            rep_d[k]   = '0;
            armed_d[k] = 1'b1;
          end else begin
            rep_d[k] = rep_q[k] + REP_W'(1);
          end
        end
        DEB_RELEASE: begin
          if (!sync2_q[k]) begin
            state_d[k] = PRESSED;
            rep_d[k]   = '0;
            armed_d[k] = 1'b1;
          end else if (deb_q[k] == DEB_LAST) begin
            state_d[k] = RELEASED;
          end else begin
            deb_d[k] = deb_q[k] + DEB_W'(1);
          end
        end
        default: state_d[k] = RELEASED;
      endcase
    end
  end

  // Add wins every same-cycle conflict; repeats are muted while both keys are held.
  always_comb begin
    both_held = (state_q[0] inside {PRESSED, DEB_RELEASE}) &&
                (state_q[1] inside {PRESSED, DEB_RELEASE});
    add_ev    = press_ev[0] | (rep_ev[0] & ~both_held);
    sub_ev    = (press_ev[1] | (rep_ev[1] & ~both_held)) & ~add_ev;
    cand      = (defer_q != 2'b00) ? defer_q : {sub_ev, add_ev};
  end

  // A tick colliding with a key pulse goes out one cycle late; the prescaler phase is untouched.
  always_comb begin
    tick_req = bus.Run && (div_q == DIV_LAST);
    div_d    = (!bus.Run || tick_req) ? '0 : div_q + DIV_W'(1);
    tick_d   = 1'b0;
    add_d    = 1'b0;
    sub_d    = 1'b0;
    pend_d   = 1'b0;
    defer_d  = 2'b00;
    if (pend_q && bus.Run) begin
      tick_d  = 1'b1;
      defer_d = cand;
    end else if (tick_req && (cand != 2'b00)) begin
      add_d  = cand[0];
      sub_d  = cand[1];
      pend_d = 1'b1;
    end else begin
      tick_d = tick_req;
      add_d  = cand[0];
      sub_d  = cand[1];
    end
  end

endmodule

// File: tb/tb_tick_key_conditioner.sv
// Scoreboard bench for tick_key_conditioner: expected pulses (kind, cycle) are queued
// when stimulus is applied and matched as Tick_out/Add/Subtract appear.
module tb_tick_key_conditioner;

  localparam int KIND_TICK = 0;
  localparam int KIND_ADD  = 1;
  localparam int KIND_SUB  = 2;
  localparam int KIND_NONE = 3;

  typedef struct {
    int kind;
    int cycle;
  } exp_t;

  logic clk = 1'b0;
  logic Reset_N;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];
  exp_t got;
  logic [2:0] obs;
  int   r;

  tick_key_conditioner_if bus ();

  tick_key_conditioner #(
    .CLK_DIV        (10),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .Clk_50MHz(clk),
    .Reset_N  (Reset_N),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic run, input logic key_add_n, input logic key_sub_n);
    bus.Run       = run;
    bus.Key_Add_N = key_add_n;
    bus.Key_Sub_N = key_sub_n;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pushExpected(input int kind, input int cycle);
    exp_t e;
    int   pos;
    e.kind  = kind;
    e.cycle = cycle;
    pos     = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cycle > cycle) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, e);
  endtask

  task automatic bounceTrain();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, (i % 2) != 0);
      waitCycles(2);
    end
  endtask

  // Every visible pulse must be the oldest outstanding expectation, in kind and cycle.
  always @(negedge clk) begin
    if (Reset_N === 1'b1) begin
      obs = {bus.Subtract, bus.Add, bus.Tick_out};
      if (obs != 3'b000) begin
        checkOutput("one_hot", $countones(obs), 1);
        for (int k = 0; k < 3; k++) begin
          if (obs[k]) begin
            if (sb.size() == 0) begin
              checkOutput("spurious_pulse_kind", k, KIND_NONE);
            end else begin
              got = sb.pop_front();
              checkOutput("pulse_kind", k, got.kind);
              checkOutput("pulse_cycle", cyc, got.cycle);
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset_N = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitCycles(3);
    checkOutput("reset_tick", bus.Tick_out, 0);
    checkOutput("reset_add", bus.Add, 0);
    checkOutput("reset_sub", bus.Subtract, 0);

    // Reset release with Run high, then a Run-low gap.
    Reset_N = 1'b1;
    pushExpected(KIND_TICK, cyc + 10);
    pushExpected(KIND_TICK, cyc + 20);
    pushExpected(KIND_TICK, cyc + 30);
    waitCycles(30);
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitCycles(25);
    applyStimulus(1'b1, 1'b1, 1'b1);
    pushExpected(KIND_TICK, cyc + 10);
    pushExpected(KIND_TICK, cyc + 20);
    waitCycles(20);
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitCycles(5);
    checkOutput("tick_missing", sb.size(), 0);

    // Clean press.
    applyStimulus(1'b0, 1'b0, 1'b1);
    pushExpected(KIND_ADD, cyc + 7);
    waitCycles(15);
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitCycles(20);
    checkOutput("clean_missing", sb.size(), 0);

    // Bounce only, then bounce followed by a steady press.
    bounceTrain();
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitCycles(20);
    bounceTrain();
    applyStimulus(1'b0, 1'b1, 1'b0);
    pushExpected(KIND_SUB, cyc + 7);
    waitCycles(15);
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitCycles(20);
    checkOutput("bounce_missing", sb.size(), 0);

    // Auto-repeat.
    applyStimulus(1'b0, 1'b0, 1'b1);
    pushExpected(KIND_ADD, cyc + 7);
    pushExpected(KIND_ADD, cyc + 27);
    pushExpected(KIND_ADD, cyc + 35);
    pushExpected(KIND_ADD, cyc + 43);
    pushExpected(KIND_ADD, cyc + 51);
    pushExpected(KIND_ADD, cyc + 59);
    waitCycles(60);
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitCycles(20);
    checkOutput("repeat_missing", sb.size(), 0);

    // Simultaneous keys.
    applyStimulus(1'b0, 1'b0, 1'b0);
    pushExpected(KIND_ADD, cyc + 7);
    waitCycles(60);
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitCycles(20);
    checkOutput("simul_missing", sb.size(), 0);

    // Press event landing on a prescaler wrap.
    applyStimulus(1'b1, 1'b1, 1'b1);
    r = cyc;
    pushExpected(KIND_TICK, r + 10);
    pushExpected(KIND_ADD, r + 20);
    pushExpected(KIND_TICK, r + 21);
    pushExpected(KIND_TICK, r + 30);
    pushExpected(KIND_TICK, r + 40);
    waitCycles(13);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitCycles(10);
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitCycles(17);
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitCycles(20);
    checkOutput("collision_missing", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
